packet_grant_multiplexer: RTL and testbench

- Downstream consumer of the static-priority/timeout arbiters.
- Drives the arbiter's requests from SIZE upstream valid/ready channels and takes the one-hot grant back.
- Forwards the granted channel's beats through a single-entry output register, holding the selection until the packet's last beat so packets never interleave.

---
 rtl/packet_grant_multiplexer.sv | 94 +++++++++
 tb/tb_packet_grant_multiplexer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/packet_grant_multiplexer.sv
// Forwards whole packets from SIZE valid/ready channels, selected by an external arbiter and locked until the last beat.
// One-cycle latency through a single output register; input_ready is withheld while that register is held by output_ready=0.
module packet_grant_multiplexer #(
   parameter int SIZE = 4,
   parameter int WIDTH = 8,
   localparam int INDEX_WIDTH = $clog2(SIZE)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [SIZE-1:0]           input_valid,
   output logic [SIZE-1:0]           input_ready,
   input  logic [SIZE*WIDTH-1:0]     input_data,
   input  logic [SIZE-1:0]           input_last,
   output logic [SIZE-1:0]           arbiter_requests,
   input  logic [SIZE-1:0]           arbiter_grant,
   output logic                      output_valid,
   input  logic                      output_ready,
   output logic [WIDTH-1:0]          output_data,
   output logic                      output_last,
   output logic [INDEX_WIDTH-1:0]    output_channel
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                  state;
   logic [INDEX_WIDTH-1:0]  locked_index;
   logic [INDEX_WIDTH-1:0]  sel;
   logic                    sel_found;
   logic                    sel_valid;
   logic                    sel_last;
   logic [WIDTH-1:0]        sel_data;
   logic [SIZE-1:0]         grant_valid;
   logic                    buffer_free;
   logic                    accept;

   assign buffer_free = !output_valid || output_ready;
   assign grant_valid = arbiter_grant & input_valid;

   // Requests are masked while locked so the arbiter's timeouts do not advance mid-packet.
   assign arbiter_requests = (state == IDLE) ? input_valid : '0;

   always_comb begin
      sel       = locked_index;
      sel_found = (state == LOCKED);
      if (state == IDLE) begin
         for (int i = SIZE - 1; i >= 0; i--) begin
            if (grant_valid[i]) begin
               sel       = INDEX_WIDTH'(i);
               sel_found = 1'b1;
            end
         end
      end

      sel_data    = '0;
      sel_last    = 1'b0;
      sel_valid   = 1'b0;
      input_ready = '0;
      for (int i = 0; i < SIZE; i++) begin
         if (sel_found && sel == INDEX_WIDTH'(i)) begin
            sel_data       = input_data[i*WIDTH +: WIDTH];
            sel_last       = input_last[i];
            sel_valid      = input_valid[i];
            input_ready[i] = buffer_free;
         end
      end
   end

   assign accept = sel_valid && buffer_free;

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         locked_index   <= '0;
         output_valid   <= 1'b0;
         output_data    <= '0;
         output_last    <= 1'b0;
         output_channel <= '0;
      end else if (accept) begin
         output_valid   <= 1'b1;
         output_data    <= sel_data;
         output_last    <= sel_last;
         output_channel <= sel;
         if (state == IDLE && !sel_last) begin
            state        <= LOCKED;
            locked_index <= sel;
         end else if (state == LOCKED && sel_last) begin
            state <= IDLE;
         end
      end else if (output_ready) begin
         output_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_packet_grant_multiplexer.sv
// Random multi-channel packet traffic against a queue-based reference of the packet multiplexer.
// Bench-side arbiter rotates priority and occasionally injects stray or multi-bit grants.
module tb_packet_grant_multiplexer;

   localparam int SIZE  = 4;
   localparam int WIDTH = 8;
   localparam int IW    = 2;

   logic                  clock = 1'b0;
   logic                  reset;
   logic [SIZE-1:0]       input_valid;
   logic [SIZE-1:0]       input_ready;
   logic [SIZE*WIDTH-1:0] input_data;
   logic [SIZE-1:0]       input_last;
   logic [SIZE-1:0]       arbiter_requests;
   logic [SIZE-1:0]       arbiter_grant;
   logic                  output_valid;
   logic                  output_ready;
   logic [WIDTH-1:0]      output_data;
   logic                  output_last;
   logic [IW-1:0]         output_channel;

   always #5 clock = ~clock;

   packet_grant_multiplexer #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
      .clock(clock),
      .reset(reset),
      .input_valid(input_valid),
      .input_ready(input_ready),
      .input_data(input_data),
      .input_last(input_last),
      .arbiter_requests(arbiter_requests),
      .arbiter_grant(arbiter_grant),
      .output_valid(output_valid),
      .output_ready(output_ready),
      .output_data(output_data),
      .output_last(output_last),
      .output_channel(output_channel)
   );

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Arbiter stand-in: rotating priority, or a stray/multi-bit grant when noise_mode is set.
   int              prio = 0;
   int              noise_mode = 0;
   logic [SIZE-1:0] noise_vec = '0;
   logic            arb_found;

   always_comb begin
      arbiter_grant = '0;
      arb_found     = 1'b0;
      if (arbiter_requests != '0) begin
         if (noise_mode != 0) begin
            arbiter_grant = noise_vec;
         end else begin
            for (int k = 0; k < SIZE; k++) begin
               if (!arb_found && arbiter_requests[(prio + k) % SIZE]) begin
                  arbiter_grant[(prio + k) % SIZE] = 1'b1;
                  arb_found = 1'b1;
               end
            end
         end
      end
   end

   typedef struct {
      logic [WIDTH-1:0] d;
      logic             l;
      logic [IW-1:0]    ch;
   } beat_t;

   beat_t            q[$];
   int               m_lock  = -1;
   int               out_pkt = -1;
   logic             prev_rst = 1'b0;
   int               src_left[SIZE];
   logic [WIDTH-1:0] src_dat[SIZE];
   int               pv, maxlen, pr, pnoise, prst;

   task automatic drive(input logic force_rst);
      logic rst_now;
      rst_now = force_rst || ($urandom_range(0, 99) < prst);
      reset = rst_now;
      output_ready = ($urandom_range(0, 99) < pr);
      prio = $urandom_range(0, SIZE - 1);
      noise_mode = ($urandom_range(0, 99) < pnoise) ? int'($urandom_range(1, 2)) : 0;
      noise_vec = '0;
      noise_vec[$urandom_range(0, SIZE - 1)] = 1'b1;
      if (noise_mode == 2) noise_vec[$urandom_range(0, SIZE - 1)] = 1'b1;
      for (int i = 0; i < SIZE; i++) begin
         if (src_left[i] == 0) begin
            src_left[i] = $urandom_range(1, maxlen);
            src_dat[i]  = WIDTH'($urandom);
         end
         input_valid[i] = !rst_now && ($urandom_range(0, 99) < pv);
         input_data[i*WIDTH +: WIDTH] = src_dat[i];
         input_last[i] = (src_left[i] == 1);
      end
   endtask

   task automatic evaluate();
      logic [SIZE-1:0] exp_req, exp_rdy;
      logic            free;
      int              sel;

      chk("out_valid", 32'(output_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
         chk("out_data", 32'(output_data), 32'(q[0].d));
         chk("out_last", 32'(output_last), 32'(q[0].l));
         chk("out_channel", 32'(output_channel), 32'(q[0].ch));
      end
      if (prev_rst) begin
         chk("rst_data", 32'(output_data), 32'h0);
         chk("rst_last", 32'(output_last), 32'h0);
         chk("rst_channel", 32'(output_channel), 32'h0);
      end

      exp_req = (m_lock < 0) ? input_valid : '0;
      chk("requests", 32'(arbiter_requests), 32'(exp_req));

      free = (q.size() == 0) || output_ready;
      sel = -1;
      if (free) begin
         if (m_lock >= 0) sel = m_lock;
         else
            for (int i = 0; i < SIZE; i++)
               if (sel < 0 && arbiter_grant[i] && input_valid[i]) sel = i;
      end
      exp_rdy = '0;
      if (sel >= 0) exp_rdy[sel] = 1'b1;
      chk("input_ready", 32'(input_ready), 32'(exp_rdy));

      prev_rst = reset;
      if (reset) begin
         q.delete();
         m_lock  = -1;
         out_pkt = -1;
      end else begin
         if (q.size() > 0 && output_ready) begin
            if (out_pkt >= 0) chk("interleave", 32'(output_channel), 32'(out_pkt));
            out_pkt = output_last ? -1 : int'(output_channel);
            void'(q.pop_front());
         end
         if (sel >= 0 && input_valid[sel]) begin
            q.push_back('{d: src_dat[sel], l: (src_left[sel] == 1), ch: IW'(sel)});
            m_lock = (src_left[sel] == 1) ? -1 : sel;
            src_left[sel]--;
            src_dat[sel] = WIDTH'($urandom);
         end
      end
   endtask

   initial begin
      reset        = 1'b1;
      input_valid  = '0;
      input_data   = '0;
      input_last   = '0;
      output_ready = 1'b0;
      for (int i = 0; i < SIZE; i++) begin
         src_left[i] = 0;
         src_dat[i]  = '0;
      end
      for (int ph = 0; ph < 5; ph++) begin
         case (ph)
            0:       begin pv = 100; maxlen = 1; pr = 100; pnoise = 0;  prst = 0; end
            1:       begin pv = 90;  maxlen = 6; pr = 60;  pnoise = 0;  prst = 0; end
            2:       begin pv = 60;  maxlen = 5; pr = 100; pnoise = 30; prst = 0; end
            3:       begin pv = 80;  maxlen = 8; pr = 40;  pnoise = 10; prst = 3; end
            default: begin pv = 100; maxlen = 4; pr = 80;  pnoise = 0;  prst = 1; end
         endcase
         for (int c = 0; c < 800; c++) begin
            @(posedge clock);
            #1;
            drive(ph == 0 && c < 2);
            @(negedge clock);
            evaluate();
         end
      end
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
